// File: rtl/io_split_pkg.sv
`default_nettype none
// io_split_pkg: shared types and constants for the ao486 IO byte splitter.
// Holds the splitter FSM states, lane geometry and the floating-bus byte.
package io_split_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int LANE_W  = 8;
  localparam int N_LANES = 4;

  localparam logic [LANE_W-1:0] FLOAT_BYTE = 8'hFF;

endpackage
`default_nettype wire

// File: rtl/io_lane_pick.sv
`default_nettype none
// io_lane_pick: lowest-set-bit picker for the 4-lane pending mask.
// Produces the one-hot lane and its 2-bit index; all zeros for an empty mask.
module io_lane_pick
  import io_split_pkg::*;
(
  input  logic [N_LANES-1:0] mask,
  output logic [N_LANES-1:0] onehot,
  output logic [1:0]         idx
);

  // Scanning from the top lets the lowest set bit overwrite any higher one.
  always_comb begin
    onehot = '0;
    idx    = '0;
    for (int i = N_LANES - 1; i >= 0; i--) begin
      if (mask[i]) begin
        onehot    = '0;
        onehot[i] = 1'b1;
        idx       = 2'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ao486_io_byte_splitter.sv
`default_nettype none
// ao486_io_byte_splitter: breaks core IO accesses of any byteenable pattern
// into ascending single-byte transducer accesses and reassembles read data.
module ao486_io_byte_splitter
  import io_split_pkg::*;
#(
  parameter int          RD_TIMEOUT = 16,
  parameter logic [7:0]  RD_FLOAT   = FLOAT_BYTE
) (
  input  logic        clk,
  input  logic        rst,

  input  logic [15:0] up_address,
  input  logic [3:0]  up_byteenable,
  input  logic        up_read,
  input  logic        up_write,
  input  logic [31:0] up_writedata,
  output logic        up_waitrequest,
  output logic [31:0] up_readdata,
  output logic        up_readdatavalid,

  output logic [15:0] down_address,
  output logic [3:0]  down_byteenable,
  output logic        down_read,
  output logic        down_write,
  output logic [31:0] down_writedata,
  input  logic        down_waitrequest,
  input  logic [31:0] down_readdata,
  input  logic        down_readdatavalid
);

  localparam logic [7:0] TIMEOUT_LIM = (RD_TIMEOUT > 255) ? 8'hFF : 8'(RD_TIMEOUT);

  state_t      state, state_n;
  logic [15:0] addr_q, addr_n;
  logic [31:0] wdata_q, wdata_n;
  logic [31:0] acc_q, acc_n;
  logic [3:0]  mask_q, mask_n;
  logic        is_rd_q, is_rd_n;
  logic [7:0]  timer_q, timer_n;

  logic [3:0]  lane_oh;
  logic [1:0]  lane_idx;
  logic [3:0]  mask_clr;
  logic        take_byte;
  logic        advance;
  logic [7:0]  byte_val;

  logic        unused_readdata_hi;
  assign unused_readdata_hi = ^down_readdata[31:8];

  io_lane_pick u_lane_pick (
    .mask   (mask_q),
    .onehot (lane_oh),
    .idx    (lane_idx)
  );

  assign mask_clr       = mask_q & ~lane_oh;
  assign up_waitrequest = (state != IDLE);
  assign down_address   = addr_q;
  assign down_writedata = wdata_q;

  always_comb begin
    state_n          = state;
    addr_n           = addr_q;
    wdata_n          = wdata_q;
    acc_n            = acc_q;
    mask_n           = mask_q;
    is_rd_n          = is_rd_q;
    timer_n          = timer_q;
    take_byte        = 1'b0;
    advance          = 1'b0;
    byte_val         = down_readdata[7:0];
    down_read        = 1'b0;
    down_write       = 1'b0;
    down_byteenable  = '0;
    up_readdatavalid = 1'b0;
    up_readdata      = '0;

    case (state)
      IDLE: begin
        if (up_read || up_write) begin
          addr_n  = up_address;
          wdata_n = up_writedata;
          mask_n  = up_byteenable;
          is_rd_n = up_read;
          acc_n   = '0;
          if (up_byteenable == 4'b0000)
            state_n = up_read ? DONE : IDLE;
          else
            state_n = ISSUE;
        end
      end

      ISSUE: begin
        down_byteenable = lane_oh;
        down_read       = is_rd_q;
        down_write      = !is_rd_q;
        if (!down_waitrequest) begin
          if (!is_rd_q) begin
            advance = 1'b1;
          end else if (down_readdatavalid) begin
            take_byte = 1'b1;
            advance   = 1'b1;
          end else begin
            state_n = WAIT_RD;
            timer_n = 8'd1;
          end
        end
      end

      // Timer counts WAIT_RD cycles starting at 1, so the float byte lands
      // on the RD_TIMEOUT-th cycle spent waiting.
      WAIT_RD: begin
        if (down_readdatavalid) begin
          take_byte = 1'b1;
          advance   = 1'b1;
        end else if (timer_q >= TIMEOUT_LIM) begin
          take_byte = 1'b1;
          byte_val  = RD_FLOAT;
          advance   = 1'b1;
        end else if (timer_q != 8'hFF) begin
          timer_n = timer_q + 8'd1;
        end
      end

      DONE: begin
        up_readdatavalid = 1'b1;
        up_readdata      = acc_q;
        state_n          = IDLE;
      end

      default: state_n = IDLE;
    endcase

    if (take_byte)
      acc_n[lane_idx*LANE_W +: LANE_W] = byte_val;

    if (advance) begin
      mask_n = mask_clr;
      if (mask_clr == 4'b0000)
        state_n = is_rd_q ? DONE : IDLE;
      else
        state_n = ISSUE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      acc_q   <= '0;
      mask_q  <= '0;
      is_rd_q <= 1'b0;
      timer_q <= '0;
    end else begin
      state   <= state_n;
      addr_q  <= addr_n;
      wdata_q <= wdata_n;
      acc_q   <= acc_n;
      mask_q  <= mask_n;
      is_rd_q <= is_rd_n;
      timer_q <= timer_n;
    end
  end

endmodule
`default_nettype wire

// File: doc/ao486_io_byte_splitter.md
Name: ao486_io_byte_splitter

Overview:
- Sits between the ao486 core's IO port and the IO transducer, directly upstream of the transducer.
- The transducer decodes only one-hot byteenable accesses, so this block splits any 8/16/32-bit core IO access into a sequence of single-byte downstream accesses.
- Write data passes through unchanged. Read bytes are collected into the correct lanes.
- Returns one readdatavalid pulse per core read, and holds the core off with waitrequest while busy.

Parameters:
- RD_TIMEOUT, 16: cycles to wait for down_readdatavalid before a byte read is abandoned.
- RD_FLOAT, 8'hFF: byte value returned for a timed-out byte read (floating ISA bus).

Ports:
- clk  in  1  Single clock.
- rst  in  1  Synchronous, active-high reset.
- up_address  in  16  Core IO port address.
- up_byteenable  in  4  Core lane enables; any pattern is legal.
- up_read  in  1  Core read request.
- up_write  in  1  Core write request.
- up_writedata  in  32  Core write data, lane-aligned.
- up_waitrequest  out  1  High while busy; a request is accepted only in a cycle where it is low.
- up_readdata  out  32  Collected read data; valid when up_readdatavalid is high.
- up_readdatavalid  out  1  One-cycle pulse per accepted read.
- down_address  out  16  Copy of the captured up_address; the transducer adds the lane offset.
- down_byteenable  out  4  One-hot lane being accessed.
- down_read  out  1  Byte read strobe.
- down_write  out  1  Byte write strobe.
- down_writedata  out  32  Copy of the captured up_writedata.
- down_waitrequest  in  1  Transducer stall.
- down_readdata  in  32  Returned byte, valid in bits [7:0] only.
- down_readdatavalid  in  1  Transducer read return; may be high in the same cycle the read is accepted.

Behaviour:
- Reset values: up_waitrequest=0, up_readdata=0, up_readdatavalid=0, down_read=0, down_write=0, down_byteenable=0, down_address=0, down_writedata=0, state=IDLE.
- Reset mid-operation abandons the transaction. No down strobe is asserted in the cycle after rst is released.
- up_waitrequest = (state != IDLE). This is combinational from the state register.
- IDLE:
  - On up_read|up_write, capture address, writedata, byteenable into the pending mask, and the op.
  - If both up_read and up_write are high, the op is a read.
  - Clear the read-data accumulator to 0. Go to ISSUE.
  - If up_byteenable==0: a read goes to DONE with data 0; a write returns to IDLE with no downstream access.
- ISSUE:
  - Drive down_byteenable = lowest set bit of the pending mask, and assert down_read or down_write.
  - The access is accepted in a cycle where down_waitrequest=0.
  - Accepted write: clear that bit in the pending mask.
  - Accepted read with down_readdatavalid high in the same cycle: place down_readdata[7:0] into the selected lane, then clear the bit.
  - Accepted read without down_readdatavalid: go to WAIT_RD and load the timeout counter.
  - After clearing, an empty mask sends a read to DONE and a write to IDLE. Otherwise stay in ISSUE for the next lane.
  - down_read and down_write are deasserted outside ISSUE.
- WAIT_RD:
  - down_readdatavalid: place the byte into the lane, clear the bit, and continue as in ISSUE.
  - Counter reaching RD_TIMEOUT: place RD_FLOAT in the lane instead and continue the same way.
  - The timeout counter is 8 bits wide and saturating.
- DONE: up_readdatavalid=1 for one cycle with up_readdata = accumulator, then go to IDLE.
- Lanes that are not enabled read as 0.
- Latency with no downstream stalls:
  - Write of k bytes: accepted at cycle 0; byte strobes in cycles 1..k; IDLE at cycle k+1.
  - Read of k bytes: up_readdatavalid at cycle k+1.
- A new request can be accepted in the cycle after DONE, or after the last write byte.
- Lanes are issued in ascending order. Non-contiguous enables (e.g. 4'b0101) are legal and each set lane is issued.
- The captured address and data are held constant for the whole transaction, regardless of what the up_* inputs do.

Decomposition:
- Shared package io_split_pkg holds:
  - the state enum: IDLE, ISSUE, WAIT_RD, DONE;
  - lane width constant 8 and lane count 4;
  - the default float byte.
- One sub-module, io_lane_pick: combinational lowest-set-bit one-hot picker on a 4-bit mask. Outputs the one-hot value plus a 2-bit lane index.

Test Plan:
- Write 0x43, byteenable 4'b0001, data 0x34, no stalls → exactly one down_write with byteenable 0001 and down_writedata[7:0]=0x34. up_waitrequest high for 1 cycle.
- Write 0x40, byteenable 4'b0011, data 0x0000_9B2E → down writes with byteenable 0001 then 0010 on consecutive cycles. Back in IDLE on cycle 3.
- Read 0x20, byteenable 4'b1111; transducer returns 0x11,0x22,0x33,0x44 with same-cycle readdatavalid → single up_readdatavalid at cycle 5 with up_readdata=0x4433_2211.
- Read 0xA1, byteenable 4'b0010; down_waitrequest held 3 cycles, readdatavalid 2 cycles after accept with 0x5A → up_readdata=0x0000_5A00. Exactly one up_readdatavalid pulse.
- Read byteenable 4'b0001 with down_readdatavalid never asserted → after RD_TIMEOUT cycles, up_readdata=0x0000_00FF.
- rst asserted during WAIT_RD of a 4-byte read → no up_readdatavalid pulse, all outputs at reset values. A following write to 0x21 completes normally.
